// File: rtl/pic_tmr0_wdt_param.sv
// TMR0, shared prescaler and watchdog for the PIC16C5X core, parametrised in timer width,
// prescaler depth and WDT base period. Define TMR0_OVF_FLAG_EN to add the tmr0_ovf pulse output.
module pic_tmr0_wdt_param #(
    parameter int TMR_W    = 8,
    parameter int PRE_W    = 8,
    parameter int WDT_BASE = 18000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tmr0_we,
    input  logic [TMR_W-1:0] tmr0_din,
    input  logic             option_we,
    input  logic [5:0]       option_din,
    input  logic             t0cki,
    input  logic             clear_WDT,
    input  logic             clear_prescaler,
    input  logic             sleep,
    input  logic             wdt_en,
    output logic [TMR_W-1:0] TMR0_out,
    output logic [5:0]       OPTION_out,
    output logic             WDT_timeout
`ifdef TMR0_OVF_FLAG_EN
    ,
    output logic             tmr0_ovf
`endif
);

    localparam int               WDT_W    = $clog2(WDT_BASE);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_BASE - 1);

    typedef struct packed {
        logic       t0cs;
        logic       t0se;
        logic       psa;
        logic [2:0] ps;
    } option_t;

    option_t          option_q;
    logic [TMR_W-1:0] tmr0_q;
    logic [PRE_W-1:0] pre_q;
    logic [WDT_W-1:0] wdt_cnt_q;
    logic [1:0]       sync_q;
    logic             t0_prev_q;
    logic [1:0]       inhibit_q;
    logic             wdt_timeout_q;

    logic [PRE_W-1:0] tmr_mask;
    logic [PRE_W-1:0] wdt_mask;
    logic             t0_rise;
    logic             t0_fall;
    logic             src_event;
    logic             tmr_active;
    logic             tmr_terminal;
    logic             wdt_terminal;
    logic             wdt_tick;
    logic             pre_clear;
    logic             pre_count;
    logic             tmr_inc;
    logic             timeout_set;

    // Prescaler taps: TMR0 divides by 2^(PS+1), the WDT by 2^PS.
    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        tmr_mask = '0;
        wdt_mask = '0;
        for (int i = 0; i < 8; i++) begin
            tmr_mask[i] = (i <= int'(option_q.ps));
            wdt_mask[i] = (i <  int'(option_q.ps));
        end
    end

    assign t0_rise   = sync_q[1] & ~t0_prev_q;
    assign t0_fall   = ~sync_q[1] & t0_prev_q;
    assign src_event = option_q.t0cs ? (option_q.t0se ? t0_fall : t0_rise) : 1'b1;

    // Events during SLEEP or the post-write inhibit window are dropped, not deferred.
    assign tmr_active = src_event & ~sleep & (inhibit_q == 2'd0);

    // The low PS+1 bits all set means the next count drops tap PS, which clocks TMR0.
    assign tmr_terminal = ((pre_q & tmr_mask) == tmr_mask);
    assign wdt_terminal = ((pre_q & wdt_mask) == wdt_mask);

    assign wdt_tick = wdt_en & (wdt_cnt_q == WDT_LAST);

    assign pre_clear = clear_prescaler
                     | (option_we & (option_din[3] != option_q.psa))
                     | (clear_WDT & option_q.psa)
                     | (tmr0_we & ~option_q.psa);

    assign pre_count = option_q.psa ? wdt_tick : tmr_active;

    // A cleared prescaler swallows the edge it would have produced this cycle.
    assign tmr_inc = option_q.psa ? tmr_active
                                  : (tmr_active & tmr_terminal & ~pre_clear);

    assign timeout_set = ~clear_WDT &
                         (option_q.psa ? (wdt_tick & wdt_terminal & ~pre_clear) : wdt_tick);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            option_q <= option_t'(6'h3F);
        end else if (option_we) begin
            option_q <= option_t'(option_din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b00;
            t0_prev_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], t0cki};
            t0_prev_q <= sync_q[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr0_q    <= '0;
            inhibit_q <= 2'd0;
        end else if (tmr0_we) begin
            tmr0_q    <= tmr0_din;
            inhibit_q <= 2'd2;
        end else begin
            if (tmr_inc) begin
                tmr0_q <= tmr0_q + TMR_W'(1);
            end
            if (inhibit_q != 2'd0) begin
                inhibit_q <= inhibit_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (pre_clear) begin
            pre_q <= '0;
        end else if (pre_count) begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt_q     <= '0;
            wdt_timeout_q <= 1'b0;
        end else begin
            wdt_timeout_q <= timeout_set;
            if (!wdt_en || clear_WDT || wdt_tick) begin
                wdt_cnt_q <= '0;
            end else begin
                wdt_cnt_q <= wdt_cnt_q + WDT_W'(1);
            end
        end
    end

`ifdef TMR0_OVF_FLAG_EN
    // wrap_q marks the edge that rolled TMR0 to zero; the flag follows one cycle later.
    logic wrap_q;
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wrap_q <= tmr_inc & ~tmr0_we & (tmr0_q == '1);
            ovf_q  <= wrap_q;
        end
    end

    assign tmr0_ovf = ovf_q;
`endif

    assign TMR0_out    = tmr0_q;
    assign OPTION_out  = option_q;
    assign WDT_timeout = wdt_timeout_q;

endmodule

// File: tb/tb_pic_tmr0_wdt_param.sv
// Directed bench for pic_tmr0_wdt_param: reset, prescaled counting, write inhibit/wrap,
// external clock edges, sleep, prescaler clear and watchdog timing with WDT_BASE=16.
module tb_pic_tmr0_wdt_param;

    localparam int TMR_W    = 8;
    localparam int PRE_W    = 8;
    localparam int WDT_BASE = 16;

    logic             clk             = 1'b0;
    logic             rst_n           = 1'b1;
    logic             tmr0_we         = 1'b0;
    logic [TMR_W-1:0] tmr0_din        = '0;
    logic             option_we       = 1'b0;
    logic [5:0]       option_din      = '0;
    logic             t0cki           = 1'b0;
    logic             clear_WDT       = 1'b0;
    logic             clear_prescaler = 1'b0;
    logic             sleep           = 1'b0;
    logic             wdt_en          = 1'b0;
    logic [TMR_W-1:0] TMR0_out;
    logic [5:0]       OPTION_out;
    logic             WDT_timeout;
`ifdef TMR0_OVF_FLAG_EN
    logic             tmr0_ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pic_tmr0_wdt_param #(
        .TMR_W   (TMR_W),
        .PRE_W   (PRE_W),
        .WDT_BASE(WDT_BASE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tmr0_we        (tmr0_we),
        .tmr0_din       (tmr0_din),
        .option_we      (option_we),
        .option_din     (option_din),
        .t0cki          (t0cki),
        .clear_WDT      (clear_WDT),
        .clear_prescaler(clear_prescaler),
        .sleep          (sleep),
        .wdt_en         (wdt_en),
        .TMR0_out       (TMR0_out),
        .OPTION_out     (OPTION_out),
`ifdef TMR0_OVF_FLAG_EN
        .tmr0_ovf       (tmr0_ovf),
`endif
        .WDT_timeout    (WDT_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns the number of negedges until WDT_timeout is seen, or max_cycles+1 if it never is.
    task automatic wait_pulse(input int max_cycles, output int cycles);
        for (cycles = 1; cycles <= max_cycles; cycles++) begin
            @(negedge clk);
            if (WDT_timeout) break;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL sim_timeout: observed no end of test, expected finish");
        $fatal(1, "time limit exceeded");
    end

    initial begin
        int cycles;
        int pulses;
        int exp_cnt;

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_tmr0", TMR0_out, 0);
        check("rst_option", OPTION_out, 6'h3F);
        check("rst_wdt", WDT_timeout, 0);
`ifdef TMR0_OVF_FLAG_EN
        check("rst_ovf", tmr0_ovf, 0);
`endif
        step(2);
        rst_n = 1'b1;
        step(1);

        // Internal clock, PSA=0, 1:4
        option_din = 6'b000001;
        option_we  = 1'b1;
        step(1);
        option_we = 1'b0;
        step(3);
        check("div4_before", TMR0_out, 0);
        step(1);
        check("div4_first", TMR0_out, 1);
        step(4);
        check("div4_second", TMR0_out, 2);
        step(2);

        // Reset mid-count, no clock edge
        rst_n = 1'b0;
        #1;
        check("midrst_tmr0", TMR0_out, 0);
        check("midrst_option", OPTION_out, 6'h3F);
        check("midrst_wdt", WDT_timeout, 0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Write FE, PSA=1 1:1: two inhibited cycles then FF, 00
        option_din = 6'b001000;
        option_we  = 1'b1;
        step(1);
        option_we = 1'b0;
        tmr0_we   = 1'b1;
        tmr0_din  = 8'hFE;
        step(1);
        tmr0_we = 1'b0;
        check("wr_fe", TMR0_out, 8'hFE);
        step(2);
        check("inhibit_fe", TMR0_out, 8'hFE);
        step(1);
        check("count_ff", TMR0_out, 8'hFF);
        step(1);
        check("wrap_00", TMR0_out, 8'h00);
`ifdef TMR0_OVF_FLAG_EN
        check("ovf_not_yet", tmr0_ovf, 0);
`endif
        step(1);
        check("after_wrap", TMR0_out, 8'h01);
`ifdef TMR0_OVF_FLAG_EN
        check("ovf_pulse", tmr0_ovf, 1);
`endif
        step(1);
`ifdef TMR0_OVF_FLAG_EN
        check("ovf_one_cycle", tmr0_ovf, 0);
`endif

        // A write of 00 on the cycle FF would wrap: write wins, no overflow
        tmr0_we  = 1'b1;
        tmr0_din = 8'hFF;
        step(1);
        tmr0_we = 1'b0;
        step(2);
        check("inhibit_ff", TMR0_out, 8'hFF);
        tmr0_we  = 1'b1;
        tmr0_din = 8'h00;
        step(1);
        tmr0_we = 1'b0;
        check("write_wins", TMR0_out, 8'h00);
        step(1);
`ifdef TMR0_OVF_FLAG_EN
        check("no_ovf_write_a", tmr0_ovf, 0);
`endif
        step(1);
        check("inhibit_00", TMR0_out, 8'h00);
`ifdef TMR0_OVF_FLAG_EN
        check("no_ovf_write_b", tmr0_ovf, 0);
`endif
        step(1);
        check("resume_01", TMR0_out, 8'h01);

        // SLEEP holds TMR0
        tmr0_we  = 1'b1;
        tmr0_din = 8'h10;
        step(1);
        tmr0_we = 1'b0;
        step(4);
        check("pre_sleep", TMR0_out, 8'h12);
        sleep = 1'b1;
        step(5);
        check("sleep_hold", TMR0_out, 8'h12);
        sleep = 1'b0;
        step(1);
        check("wake_count", TMR0_out, 8'h13);

        // PSA=0 1:2 with clear_prescaler mid-period
        option_din = 6'b000000;
        option_we  = 1'b1;
        tmr0_we    = 1'b1;
        tmr0_din   = 8'h00;
        step(1);
        option_we = 1'b0;
        tmr0_we   = 1'b0;
        step(4);
        check("div2_first", TMR0_out, 1);
        clear_prescaler = 1'b1;
        step(1);
        clear_prescaler = 1'b0;
        step(1);
        check("preclr_delay", TMR0_out, 1);
        step(1);
        check("preclr_next", TMR0_out, 2);

        // External clock, falling edges, PSA=1: each count 3 clk after its edge
        option_din = 6'b111000;
        option_we  = 1'b1;
        tmr0_we    = 1'b1;
        tmr0_din   = 8'h00;
        step(1);
        option_we = 1'b0;
        tmr0_we   = 1'b0;
        step(2);
        for (int c = 0; c < 24; c++) begin
            exp_cnt = 0;
            for (int f = 2; f <= 18; f += 4) begin
                if (f + 3 <= c) exp_cnt++;
            end
            check("t0cki_count", TMR0_out, exp_cnt);
            t0cki = (c < 19) && ((c % 4) < 2);
            step(1);
        end
        check("t0cki_total", TMR0_out, 5);

        // WDT: base 16, PSA=1, PS=2 -> period 64
        option_din = 6'b001010;
        option_we  = 1'b1;
        clear_WDT  = 1'b1;
        wdt_en     = 1'b1;
        step(1);
        option_we = 1'b0;
        clear_WDT = 1'b0;
        check("wdt_idle", WDT_timeout, 0);
        wait_pulse(100, cycles);
        check("wdt_first_period", cycles, 64);
        wait_pulse(100, cycles);
        check("wdt_second_period", cycles, 64);
        step(1);
        check("wdt_pulse_width", WDT_timeout, 0);

        // clear_WDT 60 clk after a pulse restarts the 64-clk period
        step(58);
        clear_WDT = 1'b1;
        step(1);
        clear_WDT = 1'b0;
        wait_pulse(100, cycles);
        check("wdt_after_clear", cycles, 64);

        // clear_WDT on the exact timeout cycle suppresses the pulse
        step(63);
        clear_WDT = 1'b1;
        step(1);
        clear_WDT = 1'b0;
        check("wdt_clear_wins", WDT_timeout, 0);
        wait_pulse(100, cycles);
        check("wdt_after_coincident", cycles, 64);

        // Disabled WDT gives no pulses
        wdt_en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (WDT_timeout) pulses++;
        end
        check("wdt_disabled", pulses, 0);
        wdt_en = 1'b1;
        wait_pulse(100, cycles);
        check("wdt_reenable", cycles, 64);

        // Reset while running, then no pulse on release
        step(5);
        rst_n = 1'b0;
        #1;
        check("rst2_tmr0", TMR0_out, 0);
        check("rst2_wdt", WDT_timeout, 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        check("release_wdt", WDT_timeout, 0);
        step(2);
        check("release_option", OPTION_out, 6'h3F);
        check("release_wdt_late", WDT_timeout, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
